// File: rtl/fir_filter_seq_if.sv
// Streaming and coefficient-programming bundle for fir_filter_seq.
// The sample source/driver uses master; the filter uses slave.
interface fir_filter_seq_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 12
);
  localparam int ADDR_W = $clog2(TAPS);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     clear_hist;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data, clear_hist,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data, clear_hist,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_filter_seq.sv
// Coefficient-programmable FIR filter with one time-shared multiplier.
// One sample in, TAPS multiply-accumulate cycles, one result out.
module fir_filter_seq #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 12,
  parameter int SHIFT  = 0,
  parameter int SAT    = 1
) (
  input logic             clk,
  input logic             reset,
  fir_filter_seq_if.slave bus
);
  localparam int KW     = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + KW;
  localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic signed [DATA_W-1:0] x_r [TAPS];
  logic signed [COEF_W-1:0] c_r [TAPS];
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  acc_next_s;
  logic signed [PROD_W-1:0] prod_s;
  logic [KW-1:0]            k_r;
  logic signed [OUT_W-1:0]  out_data_r;
  logic                     in_ready_s;
  logic                     out_valid_s;
  logic                     accept_s;
  logic                     coef_wr_s;

  // Shift toward -inf, then either clamp to the output range or keep the low bits.
  function automatic logic signed [OUT_W-1:0] scale_out(input logic signed [ACC_W-1:0] v);
    logic signed [EXT_W-1:0] s;
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    s  = EXT_W'(v >>> SHIFT);
    hi = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    lo = ~hi;
    if (SAT != 0) begin
      if (s > hi) begin
        scale_out = hi[OUT_W-1:0];
      end else if (s < lo) begin
        scale_out = lo[OUT_W-1:0];
      end else begin
        scale_out = s[OUT_W-1:0];
      end
    end else begin
      scale_out = s[OUT_W-1:0];
    end
  endfunction

  assign accept_s   = in_ready_s && bus.in_valid;
  assign coef_wr_s  = (state_r == IDLE) && bus.coef_we && (int'(bus.coef_addr) < TAPS);
  assign prod_s     = x_r[k_r] * c_r[k_r];
  assign acc_next_s = acc_r + ACC_W'(prod_s);

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = MAC;
        else          state_next_s = IDLE;
      end
      MAC: begin
        if (k_r == K_LAST) state_next_s = OUT;
        else               state_next_s = MAC;
      end
      OUT: begin
        if (bus.out_ready) state_next_s = IDLE;
        else               state_next_s = OUT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake outputs; a history clear blocks acceptance in the same cycle.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      IDLE:    in_ready_s  = !bus.clear_hist;
      MAC:     in_ready_s  = 1'b0;
      OUT:     out_valid_s = 1'b1;
      default: in_ready_s  = 1'b0;
    endcase
  end

  // Coefficient bank; writes land only between samples so a result never mixes banks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) c_r[i] <= {{(COEF_W-1){1'b0}}, 1'b1};
    end else if (coef_wr_s) begin
      c_r[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Delay line: cleared or shifted only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) x_r[i] <= '0;
    end else if ((state_r == IDLE) && bus.clear_hist) begin
      for (int i = 0; i < TAPS; i++) x_r[i] <= '0;
    end else if (accept_s) begin
      for (int i = TAPS - 1; i > 0; i--) x_r[i] <= x_r[i-1];
      x_r[0] <= bus.in_data;
    end
  end

  // Accumulator, tap index and the held output word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r      <= '0;
      k_r        <= '0;
      out_data_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            acc_r <= '0;
            k_r   <= '0;
          end
        end
        MAC: begin
          acc_r <= acc_next_s;
          if (k_r == K_LAST) begin
            k_r        <= '0;
            out_data_r <= scale_out(acc_next_s);
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        OUT:     acc_r <= acc_r;
        default: acc_r <= acc_r;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_filter_seq.sv
// Directed bench: a saturating and a wrapping instance run the same stimulus in lockstep.
module tb_fir_filter_seq;
  logic clk = 1'b0;
  logic reset;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  fir_filter_seq_if #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(12)) bi ();
  fir_filter_seq_if #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(12)) bw ();

  fir_filter_seq #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(12), .SHIFT(0), .SAT(1)) dut (
    .clk(clk), .reset(reset), .bus(bi.slave)
  );
  fir_filter_seq #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(12), .SHIFT(0), .SAT(0)) dut_w (
    .clk(clk), .reset(reset), .bus(bw.slave)
  );

  assign bw.in_valid   = bi.in_valid;
  assign bw.in_data    = bi.in_data;
  assign bw.out_ready  = bi.out_ready;
  assign bw.coef_we    = bi.coef_we;
  assign bw.coef_addr  = bi.coef_addr;
  assign bw.coef_data  = bi.coef_data;
  assign bw.clear_hist = bi.clear_hist;

  typedef struct {
    bit               clr;
    bit               busy_wr;
    logic signed [7:0] din;
    int               exp_sat;
    int               exp_wrap;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wcoef(input logic [1:0] a, input logic signed [7:0] d);
    bi.coef_we   = 1'b1;
    bi.coef_addr = a;
    bi.coef_data = d;
    @(posedge clk); #1;
    bi.coef_we = 1'b0;
  endtask

  // Clear with a sample presented alongside: the clear must win.
  task automatic do_clear();
    bi.clear_hist = 1'b1;
    bi.in_valid   = 1'b1;
    bi.in_data    = 8'sd99;
    #1;
    chk("clear in_ready", int'(bi.in_ready), 0);
    @(posedge clk); #1;
    bi.clear_hist = 1'b0;
    bi.in_valid   = 1'b0;
    #1;
    chk("clear not accepted", int'(bi.in_ready), 1);
  endtask

  task automatic wait_out(input string name, input int lat0);
    int lat;
    lat = lat0;
    while (!bi.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, lat, 4);
  endtask

  task automatic run_vec(input int i);
    int    n;
    string nm;
    nm = $sformatf("vec%0d", i);
    if (vecs[i].clr) do_clear();
    bi.in_data  = vecs[i].din;
    bi.in_valid = 1'b1;
    n = 0;
    while (!bi.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk({nm, " accept timeout"}, n, 0);
    @(posedge clk); #1;
    bi.in_valid = 1'b0;
    if (vecs[i].busy_wr) begin
      wcoef(2'd0, 8'sd50);
      wait_out(nm, 1);
    end else begin
      wait_out(nm, 0);
    end
    chk({nm, " sat data"}, int'(bi.out_data), vecs[i].exp_sat);
    chk({nm, " wrap data"}, int'(bw.out_data), vecs[i].exp_wrap);
    @(posedge clk); #1;
    chk({nm, " consumed"}, int'(bi.out_valid), 0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 8'sd10,   10,    10};
    vecs[1]  = '{1'b0, 1'b0, 8'sd20,   30,    30};
    vecs[2]  = '{1'b0, 1'b0, 8'sd30,   60,    60};
    vecs[3]  = '{1'b0, 1'b0, 8'sd0,    60,    60};
    vecs[4]  = '{1'b1, 1'b0, 8'sd10,   10,    10};
    vecs[5]  = '{1'b0, 1'b0, 8'sd0,    20,    20};
    vecs[6]  = '{1'b0, 1'b0, 8'sd0,    30,    30};
    vecs[7]  = '{1'b0, 1'b0, 8'sd0,    40,    40};
    vecs[8]  = '{1'b1, 1'b1, 8'sd7,    7,     7};
    vecs[9]  = '{1'b0, 1'b0, 8'sd3,    17,    17};
    vecs[10] = '{1'b0, 1'b0, 8'sd1,    77,    77};
    vecs[11] = '{1'b1, 1'b0, 8'sd127,  2047,  -255};
    vecs[12] = '{1'b0, 1'b0, 8'sd127,  2047,  -510};
    vecs[13] = '{1'b0, 1'b0, 8'sd127,  2047,  -765};
    vecs[14] = '{1'b0, 1'b0, 8'sd127,  2047,  -1020};
    vecs[15] = '{1'b0, 1'b0, -8'sd128, 2047,  -637};
    vecs[16] = '{1'b0, 1'b0, -8'sd128, -254,  -254};
    vecs[17] = '{1'b0, 1'b0, -8'sd128, -2048, 129};
    vecs[18] = '{1'b0, 1'b0, -8'sd128, -2048, 512};
    vecs[19] = '{1'b0, 1'b0, 8'sd5,    5,     5};

    reset         = 1'b1;
    bi.in_valid   = 1'b0;
    bi.in_data    = 8'sd0;
    bi.out_ready  = 1'b1;
    bi.coef_we    = 1'b0;
    bi.coef_addr  = 2'd0;
    bi.coef_data  = 8'sd0;
    bi.clear_hist = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset in_ready", int'(bi.in_ready), 1);
    chk("reset out_valid", int'(bi.out_valid), 0);
    chk("reset out_data", int'(bi.out_data), 0);
    chk("reset wrap out_data", int'(bw.out_data), 0);

    for (int i = 0; i < 4; i++) run_vec(i);

    wcoef(2'd0, 8'sd1); wcoef(2'd1, 8'sd2); wcoef(2'd2, 8'sd3); wcoef(2'd3, 8'sd4);
    for (int i = 4; i < 8; i++) run_vec(i);

    for (int i = 8; i < 10; i++) run_vec(i);
    wcoef(2'd0, 8'sd50);
    run_vec(10);

    for (int a = 0; a < 4; a++) wcoef(2'(a), 8'sd127);
    for (int i = 11; i < 19; i++) run_vec(i);

    // Reset asserted mid-MAC drops the result and restores defaults.
    bi.in_data  = 8'sd9;
    bi.in_valid = 1'b1;
    @(posedge clk); #1;
    bi.in_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_mid out_valid", int'(bi.out_valid), 0);
    chk("rst_mid in_ready", int'(bi.in_ready), 1);
    chk("rst_mid wrap out_valid", int'(bw.out_valid), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_vec(19);

    // Backpressure: output, history and handshake frozen while out_ready is low.
    bi.out_ready = 1'b0;
    bi.in_data   = 8'sd6;
    bi.in_valid  = 1'b1;
    @(posedge clk); #1;
    bi.in_valid = 1'b0;
    wait_out("bp first", 0);
    chk("bp first data", int'(bi.out_data), 11);
    bi.in_data  = 8'sd100;
    bi.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d valid", c), int'(bi.out_valid), 1);
      chk($sformatf("bp hold%0d in_ready", c), int'(bi.in_ready), 0);
      chk($sformatf("bp hold%0d data", c), int'(bi.out_data), 11);
    end
    bi.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp released valid", int'(bi.out_valid), 0);
    chk("bp released in_ready", int'(bi.in_ready), 1);
    @(posedge clk); #1;
    bi.in_valid = 1'b0;
    wait_out("bp second", 0);
    chk("bp second data", int'(bi.out_data), 111);
    chk("bp second wrap data", int'(bw.out_data), 111);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
